// File: rtl/uart_io_bridge_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : uart_io_bridge_pkg                                         |
// | Purpose  : Shared types and constants for the UART-to-I/O-bus bridge. |
// |            Frame state enumeration, command bytes, and a helper that  |
// |            identifies the byte-collecting states that can time out.   |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
package uart_io_bridge_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_ADDR_HI = 4'd1,
    ST_ADDR_LO = 4'd2,
    ST_DATA_HI = 4'd3,
    ST_DATA_LO = 4'd4,
    ST_EXEC_WR = 4'd5,
    ST_EXEC_RD = 4'd6,
    ST_TX_ACK  = 4'd7,
    ST_TX_NAK  = 4'd8,
    ST_TX_HI   = 4'd9,
    ST_TX_LO   = 4'd10
  } state_t;

  localparam logic [7:0] CMD_WR = 8'h57;  // 'W'
  localparam logic [7:0] CMD_RD = 8'h52;  // 'R'

  // States that wait for a further byte of an open frame; only these are
  // subject to the inter-byte timeout.
  function automatic logic in_frame(input state_t s);
    return (s == ST_ADDR_HI) || (s == ST_ADDR_LO) ||
           (s == ST_DATA_HI) || (s == ST_DATA_LO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_io_bridge_timeout.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : uart_io_bridge_timeout                                     |
// | Purpose  : Saturating idle counter for the bridge's inter-byte        |
// |            timeout.                                                   |
// | Ports    : clk, reset  - clock, synchronous active-high reset         |
// |            clear       - restart counting (a byte was accepted)       |
// |            enable      - count while a frame is collecting bytes      |
// |            expired     - high in the cycle the idle limit is reached  |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module uart_io_bridge_timeout #(
  parameter int TIMEOUT = 12000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int             CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);
  // The cycle holding TIMEOUT-2 is the one whose edge brings the counter to
  // TIMEOUT-1, so the abandonment lands TIMEOUT-1 clocks after the last byte.
  localparam logic [CW-1:0]  FIRE = CW'(TIMEOUT - 2);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear || !enable) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && !clear && (count == FIRE);

endmodule
`default_nettype wire

// File: rtl/uart_io_bridge.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : uart_io_bridge                                             |
// | Purpose  : Serial-side master for the J1 I/O bus. Decodes framed      |
// |            'W' AH AL DH DL (write, answered with ACK_BYTE) and        |
// |            'R' AH AL (read, answered with DH DL) commands from a UART |
// |            receiver; any other leading byte is answered NAK_BYTE.     |
// | Ports    : clk, reset          - clock, synchronous active-high reset |
// |            rx_valid/rx_data/rx_rd - receiver byte handshake           |
// |            tx_busy/tx_wr/tx_data  - transmitter byte handshake        |
// |            io_rd/io_wr/io_addr/io_dout/io_din - I/O bus master side   |
// |            active      - a frame is in progress                       |
// |            timeout_err - pulse when a stalled frame is abandoned      |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module uart_io_bridge
  import uart_io_bridge_pkg::*;
#(
  parameter int         TIMEOUT  = 12000,
  parameter logic [7:0] ACK_BYTE = 8'h4B,
  parameter logic [7:0] NAK_BYTE = 8'h3F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_rd,
  input  logic        tx_busy,
  output logic        tx_wr,
  output logic [7:0]  tx_data,
  output logic        io_rd,
  output logic        io_wr,
  output logic [15:0] io_addr,
  output logic [15:0] io_dout,
  input  logic [15:0] io_din,
  output logic        active,
  output logic        timeout_err
);

  state_t     state, state_nxt;
  logic       rx_guard;     // receiver's valid is stale for a cycle after rx_rd
  logic       tx_guard;     // transmitter's busy is stale for a cycle after tx_wr
  logic       is_rd;        // frame opened with CMD_RD
  logic [7:0] rd_lo;        // low read byte; the high byte goes straight to tx_data
  logic       accept;
  logic       send;
  logic       tmo_expired;

  uart_io_bridge_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .enable  (in_frame(state)),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    send        = 1'b0;
    io_rd       = 1'b0;
    io_wr       = 1'b0;
    timeout_err = 1'b0;

    unique case (state)
      ST_IDLE: begin
        accept = rx_valid && !rx_guard;
        if (accept) begin
          state_nxt = (rx_data == CMD_WR || rx_data == CMD_RD) ? ST_ADDR_HI : ST_TX_NAK;
        end
      end
      ST_ADDR_HI: begin
        accept = rx_valid && !rx_guard;
        if (accept) state_nxt = ST_ADDR_LO;
      end
      ST_ADDR_LO: begin
        accept = rx_valid && !rx_guard;
        if (accept) state_nxt = is_rd ? ST_EXEC_RD : ST_DATA_HI;
      end
      ST_DATA_HI: begin
        accept = rx_valid && !rx_guard;
        if (accept) state_nxt = ST_DATA_LO;
      end
      ST_DATA_LO: begin
        accept = rx_valid && !rx_guard;
        if (accept) state_nxt = ST_EXEC_WR;
      end
      ST_EXEC_WR: begin
        io_wr     = 1'b1;
        state_nxt = ST_TX_ACK;
      end
      ST_EXEC_RD: begin
        io_rd     = 1'b1;
        state_nxt = ST_TX_HI;
      end
      ST_TX_HI: begin
        send = !tx_busy && !tx_guard;
        if (send) state_nxt = ST_TX_LO;
      end
      ST_TX_LO, ST_TX_ACK, ST_TX_NAK: begin
        send = !tx_busy && !tx_guard;
        if (send) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // The timer never expires in a cycle that accepts a byte.
    if (tmo_expired) begin
      state_nxt   = ST_IDLE;
      timeout_err = 1'b1;
    end
  end

  assign rx_rd  = accept;
  assign tx_wr  = send;
  assign active = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      // rx_guard starts set so a byte left valid across reset is not taken
      // in the very first cycle out of reset.
      rx_guard <= 1'b1;
      tx_guard <= 1'b0;
      is_rd    <= 1'b0;
      rd_lo    <= 8'h00;
      io_addr  <= 16'h0000;
      io_dout  <= 16'h0000;
      tx_data  <= 8'h00;
    end else begin
      rx_guard <= rx_rd;
      tx_guard <= tx_wr;
      unique case (state)
        ST_IDLE: if (accept) begin
          is_rd <= (rx_data == CMD_RD);
          if (rx_data != CMD_WR && rx_data != CMD_RD) tx_data <= NAK_BYTE;
        end
        ST_ADDR_HI: if (accept) io_addr[15:8] <= rx_data;
        ST_ADDR_LO: if (accept) io_addr[7:0]  <= rx_data;
        ST_DATA_HI: if (accept) io_dout[15:8] <= rx_data;
        ST_DATA_LO: if (accept) io_dout[7:0]  <= rx_data;
        ST_EXEC_WR: tx_data <= ACK_BYTE;
        ST_EXEC_RD: begin
          tx_data <= io_din[15:8];
          rd_lo   <= io_din[7:0];
        end
        ST_TX_HI: if (send) tx_data <= rd_lo;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/uart_io_bridge.md
Name: uart_io_bridge

Overview:
- Serial-side bus master for the J1 I/O bus. A host PC can peek and poke I/O registers over the UART with no firmware running.
- Consumes command bytes from a UART receiver (valid/rd handshake), decodes framed read/write commands, and drives io_rd/io_wr/io_addr/io_dout.
- Returns read data or a write acknowledge through a UART transmitter (busy/wr handshake).
- Sits beside the CPU in the top level. Bus arbitration is external; the block only raises `active` while a frame is in flight.

Parameters:
- TIMEOUT, 12000, max idle clocks between bytes inside a frame before it is abandoned (1 ms at 12 MHz); must be >= 2.
- ACK_BYTE, 8'h4B, byte sent after a completed write ('K').
- NAK_BYTE, 8'h3F, byte sent for an unknown command byte ('?').

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_valid  in  1  UART receiver holds an unread byte
- rx_data  in  8  received byte
- rx_rd  out  1  one-cycle pulse: byte consumed
- tx_busy  in  1  UART transmitter busy
- tx_wr  out  1  one-cycle pulse: load tx_data
- tx_data  out  8  byte to transmit
- io_rd  out  1  one-cycle I/O read strobe
- io_wr  out  1  one-cycle I/O write strobe
- io_addr  out  16  I/O address
- io_dout  out  16  I/O write data
- io_din  in  16  I/O read data (combinational from io_addr, valid in the io_rd cycle)
- active  out  1  frame in progress (state != IDLE)
- timeout_err  out  1  one-cycle pulse on frame abandonment

Behaviour:
- Reset: state=IDLE. rx_rd, tx_wr, io_rd, io_wr, timeout_err, active = 0. io_addr, io_dout, tx_data = 0. Timeout counter = 0. Reset mid-frame aborts the frame with no strobe issued.
- Frames, all fields big-endian:
  - Write: 'W'(8'h57), AH, AL, DH, DL. Issues one io_wr cycle, then sends ACK_BYTE.
  - Read: 'R'(8'h52), AH, AL. Issues one io_rd cycle, then sends DH, DL.
  - Any other byte in IDLE: consumed, NAK_BYTE sent, return to IDLE.
- RX handshake:
  - In a byte-accepting state with rx_valid=1 and no guard active, assert rx_rd for one cycle and capture rx_data.
  - rx_valid is ignored for the cycle after rx_rd (guard), because the receiver clears valid one cycle late.
- TX handshake:
  - In a TX state with tx_busy=0 and no guard active, pulse tx_wr for one cycle with tx_data stable in that cycle.
  - tx_busy is ignored for the cycle after tx_wr (guard).
- States:
  - IDLE -> CMD decode on byte accept (W -> ADDR_HI; R -> ADDR_HI with rd flag set; else -> TX_NAK).
  - ADDR_HI -> ADDR_LO. ADDR_LO -> DATA_HI (write) or EXEC_RD (read). DATA_HI -> DATA_LO -> EXEC_WR.
  - EXEC_WR: io_wr=1 for exactly one cycle with final io_addr/io_dout -> TX_ACK.
  - EXEC_RD: io_rd=1 for exactly one cycle; io_din latched into a 16-bit read register at the end of this cycle -> TX_HI -> TX_LO -> IDLE.
  - TX_ACK, TX_NAK: one byte each -> IDLE.
- io_addr and io_dout are assembled in place (hi byte written to [15:8], lo byte to [7:0]). They hold their values after the strobe until overwritten by the next frame.
- Timeout:
  - Counter cleared on every accepted byte and whenever the state is not ADDR_HI..DATA_LO.
  - In ADDR_HI..DATA_LO it increments each clock. On reaching TIMEOUT-1: go to IDLE, pulse timeout_err, no io strobe, no tx byte.
  - The counter saturates and never wraps. TX states have no timeout.
- Bytes arriving while the block is in EXEC or TX states stay in the receiver (rx_rd=0). Overrun is the receiver's concern.
- io_rd and io_wr are never asserted together and never in consecutive cycles for the same frame.

Decomposition:
- Shared package: state enumeration and the command byte constants CMD_WR=8'h57 and CMD_RD=8'h52.
- ACK_BYTE and NAK_BYTE stay as parameters.
- One natural sub-module: `uart_io_bridge_timeout`, a saturating idle counter with clear/enable inputs and an expired output.
- The UART itself stays outside; the top level instantiates the existing buart and wires valid/busy/rd/wr.

Test Plan:
- Write: send 57 40 00 12 34 -> exactly one io_wr cycle with io_addr=16'h4000, io_dout=16'h1234; then tx_wr with tx_data=8'h4B; active returns to 0.
- Read: io_din model returns 16'hBEEF when io_addr=16'h2000; send 52 20 00 -> one io_rd cycle at io_addr=16'h2000; tx bytes BE then EF in order, each tx_wr only while tx_busy=0.
- Unknown command: send 8'h00 -> rx_rd once, tx_data=8'h3F, no io strobe, back to IDLE; a following valid read frame succeeds.
- Timeout: TIMEOUT=16; send 57 40 then stall -> timeout_err pulses exactly 15 clocks after the second byte's rx_rd; no io_wr; a subsequent full write frame completes normally.
- Backpressure: hold tx_busy=1 for 200 cycles during a read reply -> no tx_wr until busy drops; a byte arriving meanwhile is not consumed until IDLE.
- Reset mid-frame: assert reset after 57 40 00 -> all outputs 0 the next cycle; the remaining bytes 12 34 are treated as unknown commands (two NAKs).
